apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master_if.sv | 35 +++
 rtl/apb_req_master.sv | 104 ++++++++++
 tb/tb_apb_req_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// apb_req_master_if: command, response and APB signal bundle for apb_req_master
interface apb_req_master_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: turns one-at-a-time commands into APB transfers with a held response; APB_MST_TIMEOUT_EN adds an ACCESS timeout
module apb_req_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_req_master_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  hs, tmo, fin;
  assign bus.cmd_ready = !PRESET && ((state_q == IDLE && !rsp_valid_q) || (rsp_valid_q && bus.rsp_ready));
  assign hs  = bus.cmd_valid && bus.cmd_ready;
  assign fin = state_q == ACCESS && (bus.PREADY || tmo);
`ifdef APB_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  assign tmo = state_q == ACCESS && !bus.PREADY && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign bus.rsp_timeout = rsp_timeout_q;
  // count ACCESS cycles of the current transfer; cleared everywhere else
  always_comb begin
    cnt_d = (state_q == ACCESS && !fin) ? cnt_q + 1'b1 : '0;
    rsp_timeout_d = fin ? tmo : rsp_timeout_q;
  end
  // timeout counter and captured timeout flag
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`else
  assign tmo = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: SETUP always lasts one cycle, ACCESS ends on PREADY or timeout
  always_comb begin
    state_d = (state_q == IDLE)  ? (hs ? SETUP : IDLE) :
              (state_q == SETUP) ? ACCESS : (fin ? IDLE : ACCESS);
  end
  // next values of the registered APB and response outputs
  always_comb begin
    psel_d      = state_d != IDLE;
    penable_d   = state_d == ACCESS;
    pwrite_d    = hs ? bus.cmd_write : pwrite_q;
    paddr_d     = hs ? bus.cmd_addr  : paddr_q;
    pwdata_d    = hs ? bus.cmd_wdata : pwdata_q;
    pstrb_d     = hs ? (bus.cmd_write ? bus.cmd_strb : '0) : (state_d == IDLE ? '0 : pstrb_q);
    rsp_valid_d = fin || (rsp_valid_q && !bus.rsp_ready);
    rsp_rdata_d = fin ? ((pwrite_q || tmo) ? '0 : bus.PRDATA) : rsp_rdata_q;
    rsp_err_d   = fin ? (bus.PSLVERR || tmo) : rsp_err_q;
  end
  // output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: directed vector bench for apb_req_master
module tb_apb_req_master;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int errors = 0;
  int checks = 0;
  apb_req_master_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();
  apb_req_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus.master)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive_cmd(input logic wr, input logic [9:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
  endtask
  task automatic consume(input string tag);
    bus.rsp_ready = 1'b1;
    #1 chk({tag, " cmd_ready on consume"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid cleared"}, 32'(bus.rsp_valid), 32'd0);
  endtask
  task automatic run_vec(input vec_t v, input int n);
    string t;
    logic [3:0] es;
    t = $sformatf("v%0d", n);
    es = v.wr ? v.strb : 4'h0;
    @(negedge PCLK);
    drive_cmd(v.wr, v.addr, v.wdata, v.strb);
    #1 chk({t, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    chk({t, " setup psel"}, 32'(bus.PSEL), 32'd1);
    chk({t, " setup penable"}, 32'(bus.PENABLE), 32'd0);
    chk({t, " setup paddr"}, 32'(bus.PADDR), 32'(v.addr));
    chk({t, " setup pwrite"}, 32'(bus.PWRITE), 32'(v.wr));
    chk({t, " setup pstrb"}, 32'(bus.PSTRB), 32'(es));
    if (v.wr) chk({t, " setup pwdata"}, bus.PWDATA, v.wdata);
    for (int w = 0; w <= v.ws; w++) begin
      @(negedge PCLK);
      chk($sformatf("%s access%0d psel", t, w), 32'(bus.PSEL), 32'd1);
      chk($sformatf("%s access%0d penable", t, w), 32'(bus.PENABLE), 32'd1);
      chk($sformatf("%s access%0d paddr", t, w), 32'(bus.PADDR), 32'(v.addr));
      chk($sformatf("%s access%0d pstrb", t, w), 32'(bus.PSTRB), 32'(es));
      chk($sformatf("%s access%0d rsp_valid", t, w), 32'(bus.rsp_valid), 32'd0);
      bus.PREADY  = (w == v.ws);
      bus.PRDATA  = v.prdata;
      bus.PSLVERR = v.slverr;
    end
    @(negedge PCLK);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    chk({t, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({t, " psel done"}, 32'(bus.PSEL), 32'd0);
    chk({t, " penable done"}, 32'(bus.PENABLE), 32'd0);
    chk({t, " pstrb idle"}, 32'(bus.PSTRB), 32'd0);
    chk({t, " paddr hold"}, 32'(bus.PADDR), 32'(v.addr));
    chk({t, " rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({t, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({t, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    chk({t, " cmd_ready blocked"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge PCLK);
    chk({t, " rsp_valid held"}, 32'(bus.rsp_valid), 32'd1);
    chk({t, " rsp_rdata held"}, bus.rsp_rdata, v.exp_rdata);
    consume(t);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 10'h010, 32'h11111111, 4'hF, 1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 10'h111, 32'h00000042, 4'h1, 0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[3] = '{1'b0, 10'h3FC, 32'h0,        4'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vecs[4] = '{1'b0, 10'h200, 32'h0,        4'hA, 0, 32'h0000CAFE, 1'b1, 32'h0000CAFE, 1'b1};
    vecs[5] = '{1'b1, 10'h0A8, 32'h01020304, 4'h5, 2, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 10'h3FF;
    bus.cmd_wdata = 32'hFFFFFFFF;
    bus.cmd_strb  = 4'hF;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = 32'h0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("reset psel", 32'(bus.PSEL), 32'd0);
    chk("reset penable", 32'(bus.PENABLE), 32'd0);
    chk("reset pwrite", 32'(bus.PWRITE), 32'd0);
    chk("reset paddr", 32'(bus.PADDR), 32'd0);
    chk("reset pwdata", bus.PWDATA, 32'd0);
    chk("reset pstrb", 32'(bus.PSTRB), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    bus.cmd_valid = 1'b0;
    PRESET = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    // backpressure: response held while a second command waits
    @(negedge PCLK);
    drive_cmd(1'b0, 10'h020, 32'h0, 4'hF);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hA5A50001;
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0;
    drive_cmd(1'b1, 10'h030, 32'h0BADF00D, 4'h3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d cmd_ready", i), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("bp%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", i), bus.rsp_rdata, 32'hA5A50001);
      chk($sformatf("bp%0d psel", i), 32'(bus.PSEL), 32'd0);
      @(negedge PCLK);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp cmd_ready same cycle", 32'(bus.cmd_ready), 32'd1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("bp old rsp cleared", 32'(bus.rsp_valid), 32'd0);
    chk("bp second setup psel", 32'(bus.PSEL), 32'd1);
    chk("bp second setup penable", 32'(bus.PENABLE), 32'd0);
    chk("bp second paddr", 32'(bus.PADDR), 32'h030);
    chk("bp second pstrb", 32'(bus.PSTRB), 32'h3);
    chk("bp second pwdata", bus.PWDATA, 32'h0BADF00D);
    @(negedge PCLK);
    chk("bp second access penable", 32'(bus.PENABLE), 32'd1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h77777777;
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    chk("bp second rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp second rsp_rdata write", bus.rsp_rdata, 32'h0);
    consume("bp");
    // reset in the middle of ACCESS wait states
    @(negedge PCLK);
    drive_cmd(1'b0, 10'h040, 32'h0, 4'h0);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rst access penable", 32'(bus.PENABLE), 32'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("rst psel immediate", 32'(bus.PSEL), 32'd0);
    chk("rst penable immediate", 32'(bus.PENABLE), 32'd0);
    chk("rst rsp_valid immediate", 32'(bus.rsp_valid), 32'd0);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk($sformatf("post-rst%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("post-rst%0d psel", i), 32'(bus.PSEL), 32'd0);
    end
    bus.PREADY = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    // timeout after 4 ACCESS cycles with PREADY low
    @(negedge PCLK);
    drive_cmd(1'b0, 10'h050, 32'h0, 4'h0);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk($sformatf("to access%0d penable", i), 32'(bus.PENABLE), 32'd1);
      chk($sformatf("to access%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge PCLK);
    chk("to rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    chk("to rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("to psel", 32'(bus.PSEL), 32'd0);
    consume("to");
    bus.PRDATA = 32'h0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
